// File: rtl/sr_ff_monitor.sv
// SR flip-flop monitor: models the expected q of an observed SR flip-flop,
// compares the observed q one cycle later, and counts errors and illegal
// s=r=1 cycles. Optional q_bar complement check enabled by SR_MON_QBAR_CHECK_EN.
module sr_ff_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic       ff_reset,
  input  logic       s,
  input  logic       r,
  input  logic       q,
  input  logic       q_bar,
  output logic       exp_q,
  output logic [1:0] mon_state,
  output logic       err_pulse,
  output logic       err_sticky,
  output logic [7:0] err_count,
  output logic [7:0] illegal_count
);

  typedef enum logic [1:0] {
    StInit  = 2'b00,
    StTrack = 2'b01,
    StUndef = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic       exp_q_q, exp_q_d;
  logic       err_pulse_q;
  logic       err_sticky_q;
  logic [7:0] err_count_q;
  logic [7:0] illegal_count_q;

  logic       illegal;
  logic       q_err;
  logic       qbar_err;
  logic       err;

  // s=r=1 is only illegal when ff_reset is not overriding it.
  assign illegal = s && r && !ff_reset;

  // exp_q_q still holds the value registered at the previous edge.
  assign q_err = (state_q == StTrack) && (q != exp_q_q);

`ifdef SR_MON_QBAR_CHECK_EN
  assign qbar_err = (state_q != StInit) && (q_bar == q);
`else
  logic unused_q_bar;
  assign unused_q_bar = q_bar;
  assign qbar_err     = 1'b0;
`endif

  assign err = q_err || qbar_err;

  // State register and all monitor state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= StInit;
      exp_q_q         <= 1'b0;
      err_pulse_q     <= 1'b0;
      err_sticky_q    <= 1'b0;
      err_count_q     <= 8'd0;
      illegal_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      exp_q_q      <= exp_q_d;
      err_pulse_q  <= err;
      err_sticky_q <= err_sticky_q || err;
      if (err && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
      if (illegal && (illegal_count_q != 8'hFF)) begin
        illegal_count_q <= illegal_count_q + 8'd1;
      end
    end
  end

  // Next-state: FSM transitions and the SR model update.
  always_comb begin
    state_d = state_q;
    exp_q_d = exp_q_q;

    if (ff_reset) begin
      exp_q_d = 1'b0;
    end else if (s && !r) begin
      exp_q_d = 1'b1;
    end else if (!s && r) begin
      exp_q_d = 1'b0;
    end

    unique case (state_q)
      StInit:  state_d = StTrack;
      StTrack: if (illegal) state_d = StUndef;
      StUndef: if (ff_reset || (s != r)) state_d = StTrack;
      default: state_d = StInit;
    endcase
  end

  // Outputs are direct register views.
  always_comb begin
    exp_q         = exp_q_q;
    mon_state     = state_q;
    err_pulse     = err_pulse_q;
    err_sticky    = err_sticky_q;
    err_count     = err_count_q;
    illegal_count = illegal_count_q;
  end

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Directed, table-driven bench for sr_ff_monitor.
module tb_sr_ff_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       ff_reset;
  logic       s;
  logic       r;
  logic       q;
  logic       q_bar;
  logic       exp_q;
  logic [1:0] mon_state;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_count;
  logic [7:0] illegal_count;

  int errors = 0;
  int checks = 0;

  sr_ff_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .ff_reset      (ff_reset),
    .s             (s),
    .r             (r),
    .q             (q),
    .q_bar         (q_bar),
    .exp_q         (exp_q),
    .mon_state     (mon_state),
    .err_pulse     (err_pulse),
    .err_sticky    (err_sticky),
    .err_count     (err_count),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ff;
    logic       s;
    logic       r;
    logic       q;
    logic       eq;
    logic [1:0] st;
    logic       ep;
    logic       es;
    logic [7:0] ec;
    logic [7:0] ic;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step(input logic rst, input logic ffr, input logic si, input logic ri,
                      input logic qi, input logic qbi);
    reset    = rst;
    ff_reset = ffr;
    s        = si;
    r        = ri;
    q        = qi;
    q_bar    = qbi;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic eq, input logic [1:0] st, input logic ep,
                         input logic es, input logic [7:0] ec, input logic [7:0] ic);
    chk({tag, ".exp_q"}, int'(exp_q), int'(eq));
    chk({tag, ".mon_state"}, int'(mon_state), int'(st));
    chk({tag, ".err_pulse"}, int'(err_pulse), int'(ep));
    chk({tag, ".err_sticky"}, int'(err_sticky), int'(es));
    chk({tag, ".err_count"}, int'(err_count), int'(ec));
    chk({tag, ".illegal_count"}, int'(illegal_count), int'(ic));
  endtask

  initial begin
    logic exp_pulse;
    logic [7:0] exp_ec;

    //            ff    s     r     q     eq    st     ep    es    ec    ic
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 8'd0}; // INIT, no compare
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'd1, 8'd0}; // q mismatch
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 8'd1, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 8'd1, 8'd1}; // enter UNDEF
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'd1, 8'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'd1, 8'd3}; // leave UNDEF
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'd1, 8'd3}; // ff_reset wins
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 8'd2, 8'd3}; // q mismatch
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 8'd2, 8'd4};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'd2, 8'd4}; // UNDEF exit
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'd2, 8'd4};

    // Reset held low two edges with busy inputs; reset must override them.
    reset = 1'b0; ff_reset = 1'b0; s = 1'b0; r = 1'b0; q = 1'b0; q_bar = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_all("rst0", 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("rst1", 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0);

    for (int i = 0; i < 19; i++) begin
      step(1'b1, vecs[i].ff, vecs[i].s, vecs[i].r, vecs[i].q, ~vecs[i].q);
      chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].st, vecs[i].ep, vecs[i].es,
              vecs[i].ec, vecs[i].ic);
    end

    // q_bar equal to q while in UNDEF: an error only with the check compiled in.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_all("qb_enter", 1'b0, 2'b10, 1'b0, 1'b1, 8'd2, 8'd5);
`ifdef SR_MON_QBAR_CHECK_EN
    exp_pulse = 1'b1;
    exp_ec    = 8'd3;
`else
    exp_pulse = 1'b0;
    exp_ec    = 8'd2;
`endif
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_all("qb_bad", 1'b0, 2'b10, exp_pulse, 1'b1, exp_ec, 8'd6);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_all("qb_exit", 1'b0, 2'b01, 1'b0, 1'b1, exp_ec, 8'd6);

    // Reset on an edge carrying a q mismatch: the compare is dropped.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("midrst", 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("midrst_init", 1'b0, 2'b01, 1'b0, 1'b0, 8'd0, 8'd0);

    // 300 mismatching TRACK cycles: pulse every cycle, count saturates.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("sat_pulse%0d", i), int'(err_pulse), 1);
    end
    chk_all("sat_err", 1'b0, 2'b01, 1'b1, 1'b1, 8'd255, 8'd0);

    // 300 illegal cycles: illegal_count saturates, no further errors.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    chk_all("sat_ill", 1'b0, 2'b10, 1'b0, 1'b1, 8'd255, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_ff_monitor.md
SR_FF_MONITOR -- requirements
Module: sr_ff_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-004 ff_reset  input  1  observed flip-flop reset, active-high; forces expected q to 0.
REQ-005 s  input  1  observed set stimulus.
REQ-006 r  input  1  observed reset stimulus.
REQ-007 q  input  1  observed flip-flop output.
REQ-008 q_bar  input  1  observed complementary output.
REQ-009 exp_q  output  1  model-expected q.
REQ-010 mon_state  output  2  INIT=00, TRACK=01, UNDEF=10; 11 unused.
REQ-011 err_pulse  output  1  one-cycle pulse per detected error cycle.
REQ-012 err_sticky  output  1  set on first error, held until reset.
REQ-013 err_count  output  8  error cycles, saturating at 255.
REQ-014 illegal_count  output  8  s=r=1 cycles, saturating at 255.

Function
REQ-015 Model update per edge, by priority:
- ff_reset=1: exp_q <= 0.
- s=1, r=0: exp_q <= 1.
- s=0, r=1: exp_q <= 0.
- s=0, r=0: exp_q holds.
- s=1, r=1: exp_q holds and the block enters UNDEF.
REQ-016 Compare latency is one cycle: at edge k+1, q SHALL be compared with the exp_q value registered at edge k.
REQ-017 FSM transitions:
- INIT -> TRACK: unconditional on the first edge after reset release; no compare in INIT.
- TRACK -> UNDEF: s=r=1 with ff_reset=0.
- UNDEF -> TRACK: ff_reset=1, or s differs from r.
- UNDEF -> UNDEF: otherwise.
REQ-018 q compare SHALL run only while mon_state=TRACK at the compare edge; a mismatch is an error.
REQ-019 An s=r=1 cycle with ff_reset=0 SHALL increment illegal_count; with ff_reset=1 it SHALL NOT, since ff_reset has priority.
REQ-020 Error cycle handling:
- err_pulse=1 for exactly the following cycle.
- err_count increments by 1, even if several error sources fire in the same cycle.
- err_sticky set.
REQ-021 Both counters SHALL saturate at 8'hFF and never wrap; err_pulse and err_sticky still respond at saturation.
REQ-022 Reset asserted mid-operation SHALL discard pending compares; no error is reported for the edge on which reset is sampled low.

Reset
REQ-023 Values while reset=0 at a rising edge:
- exp_q=0, mon_state=INIT.
- err_pulse=0, err_sticky=0.
- err_count=0, illegal_count=0.
- Internal pipeline registers = 0.
REQ-024 Reset SHALL override ff_reset and every other input.

Configuration
REQ-025 Macro SR_MON_QBAR_CHECK_EN, when defined:
- Each edge outside INIT SHALL also check q_bar == ~q, in TRACK and UNDEF alike.
- A violation is an error cycle per REQ-020.
REQ-026 Without SR_MON_QBAR_CHECK_EN, q_bar SHALL be ignored and generate no logic; all other behaviour is unchanged.

Verification
REQ-027 Reset low 2 cycles, then release -> all outputs 0, mon_state 00 -> 01 after one edge, err_count=0.
REQ-028 Drive s=1 r=0, with q=1 from the next cycle onward -> exp_q=1, no err_pulse; then hold q=0 for one cycle -> one err_pulse, err_count=1, err_sticky=1.
REQ-029 Drive s=1 r=1 for 3 cycles, with q toggling -> illegal_count=3, mon_state=10, no err_pulse; then s=0 r=1 -> mon_state=01, exp_q=0.
REQ-030 ff_reset=1 with s=r=1 -> exp_q=0, illegal_count unchanged, mon_state stays 01.
REQ-031 Force a q mismatch on 300 consecutive TRACK cycles -> err_count stops at 255, err_pulse high every cycle.
REQ-032 SR_MON_QBAR_CHECK_EN defined, q=1 and q_bar=1 in UNDEF -> err_pulse=1, err_count +1; with the macro undefined -> no error.
